// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared types and constants for the CPUID dispatcher arbiter
package dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Quiet cycles required after a response before the dispatcher is offered again
  localparam int DRAIN_LEN = 4;

  // Width of the allocation statistics counters
  localparam int CNT_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             found
);

  // Scan N positions beginning one past last_grant, wrapping; first set bit wins
  always_comb begin
    int             pos;
    logic [IDX_W-1:0] p;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    p         = '0;
    for (int i = 1; i <= N; i++) begin
      pos = int'(last_grant) + i;
      if (pos >= N) pos = pos - N;
      p = IDX_W'(pos);
      if (!found && req[p]) begin
        found     = 1'b1;
        grant[p]  = 1'b1;
        grant_idx = p;
      end
    end
  end

endmodule

// File: rtl/dispatcher_cpuid_arbiter.sv
// rtl/dispatcher_cpuid_arbiter.sv - round-robin sharing of one CPUID dispatcher among requesters
module dispatcher_cpuid_arbiter
  import dispatcher_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = 5,
  parameter int CPUID_W = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       in_req_ctl,
  input  logic [NUM_REQ*KEY_W-1:0] in_req_key,
  output logic [NUM_REQ-1:0]       out_req_ack,
  output logic [NUM_REQ-1:0]       out_req_valid,
  output logic [CPUID_W-1:0]       out_req_cpuid,
  output logic                     out_disp_ctl,
  output logic [KEY_W-1:0]         out_disp_key,
  input  logic                     in_disp_ack,
  input  logic                     in_disp_valid,
  input  logic [CPUID_W-1:0]       in_disp_cpuid,
  input  logic                     in_cnt_clr,
  output logic [CNT_W-1:0]         out_alloc_cnt,
  output logic [CNT_W-1:0]         out_invalid_cnt,
  output logic [CNT_W-1:0]         out_timeout_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int DRN_W = $clog2(DRAIN_LEN);

  state_t             state, state_d;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [TMR_W-1:0]   timer;
  logic [DRN_W-1:0]   drain_cnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_found;

  logic do_grant, do_ack, do_timeout, do_release;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (in_req_ctl),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .found      (arb_found)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and one-cycle action strobes; an ack beats a same-cycle timeout
  always_comb begin
    state_d    = state;
    do_grant   = 1'b0;
    do_ack     = 1'b0;
    do_timeout = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          do_grant = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (in_disp_ack) begin
          do_ack  = 1'b1;
          state_d = RESP;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (!in_req_ctl[grant_idx]) begin
          do_release = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_disp_ack && drain_cnt == DRN_W'(DRAIN_LEN - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, dispatcher request and key, wait timer, drain quiet counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= IDX_W'(NUM_REQ - 1);
      grant_idx    <= '0;
      grant_oh     <= '0;
      timer        <= '0;
      drain_cnt    <= '0;
      out_disp_ctl <= 1'b0;
      out_disp_key <= '0;
    end else begin
      if (do_grant) begin
        grant_idx    <= arb_idx;
        grant_oh     <= arb_grant;
        out_disp_key <= in_req_key[arb_idx*KEY_W +: KEY_W];
        out_disp_ctl <= 1'b1;
        timer        <= '0;
      end else if (state == REQ) begin
        timer <= timer + 1'b1;
      end
      if (do_ack || do_timeout) out_disp_ctl <= 1'b0;
      if (do_release) begin
        last_grant <= grant_idx;
        drain_cnt  <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= in_disp_ack ? '0 : drain_cnt + 1'b1;
      end
    end
  end

  // Result returned to the granted requester, held until it drops its request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_req_ack   <= '0;
      out_req_valid <= '0;
      out_req_cpuid <= '0;
    end else if (do_ack) begin
      out_req_ack   <= grant_oh;
      out_req_valid <= in_disp_valid ? grant_oh : '0;
      out_req_cpuid <= in_disp_cpuid;
    end else if (do_timeout) begin
      out_req_ack   <= grant_oh;
      out_req_valid <= '0;
      out_req_cpuid <= '0;
    end else if (do_release) begin
      out_req_ack   <= '0;
      out_req_valid <= '0;
      out_req_cpuid <= '0;
    end
  end

  // Statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_alloc_cnt   <= '0;
      out_invalid_cnt <= '0;
      out_timeout_cnt <= '0;
    end else if (in_cnt_clr) begin
      out_alloc_cnt   <= '0;
      out_invalid_cnt <= '0;
      out_timeout_cnt <= '0;
    end else begin
      if (do_ack && in_disp_valid)  out_alloc_cnt   <= out_alloc_cnt + 1'b1;
      if (do_ack && !in_disp_valid) out_invalid_cnt <= out_invalid_cnt + 1'b1;
      if (do_timeout)               out_timeout_cnt <= out_timeout_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatcher_cpuid_arbiter.sv
// tb/tb_dispatcher_cpuid_arbiter.sv - self-checking bench with behavioural model for the dispatcher arbiter
module tb_dispatcher_cpuid_arbiter;

  localparam int N  = 4;
  localparam int KW = 5;
  localparam int CW = 5;
  localparam int TO = 8;
  localparam int QUIET_NEEDED = 4;

  localparam int P_FREE  = 0;
  localparam int P_ASK   = 1;
  localparam int P_GIVE  = 2;
  localparam int P_QUIET = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_ctl = '0;
  logic [N*KW-1:0] req_key = '0;
  logic [N-1:0]  req_ack, req_valid;
  logic [CW-1:0] req_cpuid;
  logic          disp_ctl;
  logic [KW-1:0] disp_key;
  logic          disp_ack = 1'b0;
  logic          disp_valid = 1'b0;
  logic [CW-1:0] disp_cpuid = '0;
  logic          cnt_clr = 1'b0;
  logic [31:0]   alloc_cnt, invalid_cnt, timeout_cnt;

  int checks = 0;
  int failures = 0;

  dispatcher_cpuid_arbiter #(
    .NUM_REQ (N),
    .KEY_W   (KW),
    .CPUID_W (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_req_ctl      (req_ctl),
    .in_req_key      (req_key),
    .out_req_ack     (req_ack),
    .out_req_valid   (req_valid),
    .out_req_cpuid   (req_cpuid),
    .out_disp_ctl    (disp_ctl),
    .out_disp_key    (disp_key),
    .in_disp_ack     (disp_ack),
    .in_disp_valid   (disp_valid),
    .in_disp_cpuid   (disp_cpuid),
    .in_cnt_clr      (cnt_clr),
    .out_alloc_cnt   (alloc_cnt),
    .out_invalid_cnt (invalid_cnt),
    .out_timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the dispatcher, how long it has waited, how quiet the drain is
  int            phase = P_FREE;
  int            m_owner = 0;
  int            m_prev = N - 1;
  int            m_wait = 0;
  int            m_quiet = 0;
  logic [N-1:0]  e_ack = '0, e_valid = '0;
  logic [CW-1:0] e_cpuid = '0;
  logic          e_ctl = 1'b0;
  logic [KW-1:0] e_key = '0;
  logic [31:0]   e_alloc = 0, e_inval = 0, e_tmo = 0;

  task automatic model_step();
    logic [N-1:0] oh;
    bit inc_a, inc_i, inc_t, found;
    int c;
    inc_a = 0; inc_i = 0; inc_t = 0; found = 0;
    if (reset) begin
      phase = P_FREE; m_prev = N - 1; m_wait = 0; m_quiet = 0; m_owner = 0;
      e_ack = '0; e_valid = '0; e_cpuid = '0; e_ctl = 1'b0; e_key = '0;
      e_alloc = 0; e_inval = 0; e_tmo = 0;
      return;
    end
    oh = '0;
    oh[m_owner] = 1'b1;
    case (phase)
      P_FREE: begin
        for (int k = 1; k <= N; k++) begin
          c = (m_prev + k) % N;
          if (!found && req_ctl[c]) begin
            found = 1;
            m_owner = c;
          end
        end
        if (found) begin
          e_ctl = 1'b1;
          e_key = req_key[m_owner*KW +: KW];
          m_wait = 0;
          phase = P_ASK;
        end
      end
      P_ASK: begin
        if (disp_ack) begin
          e_ctl = 1'b0; e_ack = oh; e_valid = disp_valid ? oh : '0; e_cpuid = disp_cpuid;
          if (disp_valid) inc_a = 1; else inc_i = 1;
          phase = P_GIVE;
        end else if (m_wait == TO - 1) begin
          e_ctl = 1'b0; e_ack = oh; e_valid = '0; e_cpuid = '0;
          inc_t = 1;
          phase = P_GIVE;
        end else begin
          m_wait++;
        end
      end
      P_GIVE: begin
        if (!req_ctl[m_owner]) begin
          e_ack = '0; e_valid = '0; e_cpuid = '0;
          m_prev = m_owner;
          m_quiet = 0;
          phase = P_QUIET;
        end
      end
      default: begin
        if (disp_ack) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == QUIET_NEEDED) phase = P_FREE;
        end
      end
    endcase
    if (cnt_clr) begin
      e_alloc = 0; e_inval = 0; e_tmo = 0;
    end else begin
      if (inc_a) e_alloc = e_alloc + 1;
      if (inc_i) e_inval = e_inval + 1;
      if (inc_t) e_tmo = e_tmo + 1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Every cycle: compare DUT outputs with the model on the falling edge
  initial forever begin
    @(negedge clk);
    chk("req_ack", 32'(req_ack), 32'(e_ack));
    chk("req_valid", 32'(req_valid), 32'(e_valid));
    if (e_ack != '0) chk("req_cpuid", 32'(req_cpuid), 32'(e_cpuid));
    chk("disp_ctl", 32'(disp_ctl), 32'(e_ctl));
    if (e_ctl) chk("disp_key", 32'(disp_key), 32'(e_key));
    chk("alloc_cnt", alloc_cnt, e_alloc);
    chk("invalid_cnt", invalid_cnt, e_inval);
    chk("timeout_cnt", timeout_cnt, e_tmo);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_key(input int i, input logic [KW-1:0] k);
    req_key[i*KW +: KW] = k;
  endtask

  int order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int got;

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_ctl", 32'(disp_ctl), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    step();

    // Single request, dispatcher acks on the fourth edge
    set_key(0, 5'd5);
    req_ctl[0] = 1'b1;
    step();
    chk("t1_ctl", 32'(disp_ctl), 32'd1);
    chk("t1_key", 32'(disp_key), 32'd5);
    step(); step(); step();
    disp_ack = 1'b1; disp_valid = 1'b1; disp_cpuid = 5'd5;
    step();
    disp_ack = 1'b0; disp_valid = 1'b0; disp_cpuid = '0;
    chk("t1_ack", 32'(req_ack), 32'h1);
    chk("t1_valid", 32'(req_valid), 32'h1);
    chk("t1_cpuid", 32'(req_cpuid), 32'd5);
    chk("t1_alloc", alloc_cnt, 32'd1);
    chk("t1_ctl_low", 32'(disp_ctl), 32'd0);
    req_ctl[0] = 1'b0;
    repeat (8) step();

    // Invalid result
    set_key(3, 5'd9);
    req_ctl[3] = 1'b1;
    step();
    disp_ack = 1'b1; disp_valid = 1'b0; disp_cpuid = 5'd17;
    step();
    disp_ack = 1'b0; disp_cpuid = '0;
    chk("t2_ack", 32'(req_ack), 32'h8);
    chk("t2_valid", 32'(req_valid), 32'h0);
    chk("t2_invalid", invalid_cnt, 32'd1);
    req_ctl[3] = 1'b0;
    repeat (8) step();

    // Timeout, then a late dispatcher ack stretches the drain
    set_key(1, 5'd3);
    req_ctl[1] = 1'b1;
    step();
    chk("t3_ctl", 32'(disp_ctl), 32'd1);
    repeat (7) step();
    chk("t3_pre_ack", 32'(req_ack), 32'h0);
    chk("t3_pre_ctl", 32'(disp_ctl), 32'd1);
    step();
    chk("t3_ack", 32'(req_ack), 32'h2);
    chk("t3_valid", 32'(req_valid), 32'h0);
    chk("t3_ctl_low", 32'(disp_ctl), 32'd0);
    chk("t3_tmo", timeout_cnt, 32'd1);
    req_ctl[1] = 1'b0;
    set_key(2, 5'd21);
    req_ctl[2] = 1'b1;
    step();
    disp_ack = 1'b1; disp_valid = 1'b1; disp_cpuid = 5'd30;
    step();
    disp_ack = 1'b0; disp_valid = 1'b0; disp_cpuid = '0;
    chk("t3_late_not_fwd", 32'(req_ack), 32'h0);
    repeat (4) step();
    chk("t3_drain_ext", 32'(disp_ctl), 32'd0);
    step();
    chk("t3_next_ctl", 32'(disp_ctl), 32'd1);
    chk("t3_next_key", 32'(disp_key), 32'd21);

    // Ack arriving on the timeout cycle wins
    repeat (7) step();
    chk("t4_pre_ack", 32'(req_ack), 32'h0);
    disp_ack = 1'b1; disp_valid = 1'b1; disp_cpuid = 5'd12;
    step();
    disp_ack = 1'b0; disp_valid = 1'b0; disp_cpuid = '0;
    chk("t4_ack", 32'(req_ack), 32'h4);
    chk("t4_valid", 32'(req_valid), 32'h4);
    chk("t4_cpuid", 32'(req_cpuid), 32'd12);
    chk("t4_alloc", alloc_cnt, 32'd2);
    chk("t4_tmo", timeout_cnt, 32'd1);
    req_ctl[2] = 1'b0;
    repeat (8) step();

    // Reset in the middle of a request
    set_key(2, 5'd7);
    req_ctl[2] = 1'b1;
    step(); step();
    reset = 1'b1;
    #1;
    chk("t5_ctl", 32'(disp_ctl), 32'd0);
    chk("t5_ack", 32'(req_ack), 32'h0);
    chk("t5_alloc", alloc_cnt, 32'd0);
    chk("t5_tmo", timeout_cnt, 32'd0);
    for (int i = 0; i < N; i++) set_key(i, 5'(i + 10));
    req_ctl = '1;
    step();
    reset = 1'b0;

    // Fairness with all requesters busy and an immediate dispatcher
    for (int cyc = 0; cyc < 200 && order.size() < 5; cyc++) begin
      disp_ack = disp_ctl && !disp_ack;
      disp_valid = 1'b1;
      disp_cpuid = 5'($urandom);
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] && req_ctl[i]) begin
          order.push_back(i);
          req_ctl[i] = 1'b0;
        end else if (!req_ctl[i]) begin
          req_ctl[i] = 1'b1;
        end
      end
      step();
    end
    disp_ack = 1'b0;
    chk("fair_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      got = (k < order.size()) ? order[k] : 99;
      chk("fair_order", 32'(got), 32'(exp_order[k]));
    end

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ctl[i]) begin
          if (req_ack[i]) begin
            if ($urandom_range(1, 0) != 0) req_ctl[i] = 1'b0;
          end else if ($urandom_range(31, 0) == 0) begin
            req_ctl[i] = 1'b0;
          end
        end else if ($urandom_range(3, 0) == 0) begin
          req_ctl[i] = 1'b1;
          set_key(i, 5'($urandom));
        end
      end
      if (disp_ctl) disp_ack = ($urandom_range(5, 0) == 0);
      else          disp_ack = ($urandom_range(9, 0) == 0);
      disp_valid = ($urandom_range(1, 0) != 0);
      disp_cpuid = 5'($urandom);
      cnt_clr = ($urandom_range(199, 0) == 0);
      step();
    end
    req_ctl = '0;
    disp_ack = 1'b0;
    cnt_clr = 1'b0;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
